// File: rtl/rot_addr_gen.sv
// rot_addr_gen: command address generator for tiled image rotation.
// Walks the padded source image tile by tile in row-major order. For each
// tile it issues TILE read commands (one per source line), then TILE write
// commands to the rotated destination tile position.
// Ports:
//   I_AG_HCLK, I_AG_HRESET_N      clock, async active-low reset
//   I_AG_START, I_AG_ABORT        job start pulse, synchronous abort
//   I_AG_HEIGHT/WIDTH             source size in pixels
//   I_AG_DEGREES/DIRECTION        rotation amount and sense (1=clockwise)
//   I_AG_SRC_BASE/DST_BASE        base byte addresses
//   I_AG_CMD_READY                downstream handshake
//   O_AG_CMD_VALID/ADDR/WRITE     command out (held while stalled)
//   O_AG_CMD_BEATS                constant beats per line command
//   O_AG_BUSY/DONE/ERR            job status
//   O_AG_NEW_H/NEW_W              destination dimensions
module rot_addr_gen #(
  parameter int ADDR_W  = 32,
  parameter int DIM_W   = 16,
  parameter int TILE_LG = 3,
  parameter int BPP     = 3,
  parameter int BEAT_B  = 4,
  parameter int MAX_DIM = 16383
) (
  input  logic              I_AG_HCLK,
  input  logic              I_AG_HRESET_N,
  input  logic              I_AG_START,
  input  logic              I_AG_ABORT,
  input  logic [DIM_W-1:0]  I_AG_HEIGHT,
  input  logic [DIM_W-1:0]  I_AG_WIDTH,
  input  logic [1:0]        I_AG_DEGREES,
  input  logic              I_AG_DIRECTION,
  input  logic [ADDR_W-1:0] I_AG_SRC_BASE,
  input  logic [ADDR_W-1:0] I_AG_DST_BASE,
  input  logic              I_AG_CMD_READY,
  output logic              O_AG_CMD_VALID,
  output logic [ADDR_W-1:0] O_AG_CMD_ADDR,
  output logic              O_AG_CMD_WRITE,
  output logic [7:0]        O_AG_CMD_BEATS,
  output logic              O_AG_BUSY,
  output logic              O_AG_DONE,
  output logic              O_AG_ERR,
  output logic [DIM_W-1:0]  O_AG_NEW_H,
  output logic [DIM_W-1:0]  O_AG_NEW_W
);

  localparam int TILE  = 1 << TILE_LG;
  localparam int BEATS = TILE * BPP / BEAT_B;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   src_q, dst_q;
  logic [DIM_W-1:0]    pw_q, dw_q, th_q, tw_q;
  logic [DIM_W-1:0]    tr_q, tc_q;
  logic [TILE_LG-1:0]  line_q;
  logic [1:0]          rot_q;

  assign O_AG_CMD_BEATS = 8'(BEATS);

  // Start-time decode of the raw inputs
  logic [DIM_W:0]   h_sum, w_sum;
  logic [DIM_W-1:0] th_in, tw_in, ph_in, pw_in;
  logic [1:0]       rot_in;
  logic             legal;

  assign h_sum  = {1'b0, I_AG_HEIGHT} + (DIM_W+1)'(TILE - 1);
  assign w_sum  = {1'b0, I_AG_WIDTH}  + (DIM_W+1)'(TILE - 1);
  assign th_in  = DIM_W'(h_sum >> TILE_LG);
  assign tw_in  = DIM_W'(w_sum >> TILE_LG);
  assign ph_in  = th_in << TILE_LG;
  assign pw_in  = tw_in << TILE_LG;
  // counter-clockwise D is clockwise (4-D) mod 4, i.e. -D in two bits
  assign rot_in = I_AG_DIRECTION ? I_AG_DEGREES : 2'd0 - I_AG_DEGREES;
  assign legal  = (I_AG_HEIGHT != '0) && (I_AG_WIDTH != '0) &&
                  (I_AG_HEIGHT <= DIM_W'(MAX_DIM)) && (I_AG_WIDTH <= DIM_W'(MAX_DIM));

  // Position of the command that follows the current handshake
  logic               last_line, last_col, last_row;
  logic [DIM_W-1:0]   nxt_tr, nxt_tc;
  logic [TILE_LG-1:0] nxt_line;
  logic               nxt_write;

  assign last_line = (line_q == TILE_LG'(TILE - 1));
  assign last_col  = (tc_q == tw_q - DIM_W'(1));
  assign last_row  = (tr_q == th_q - DIM_W'(1));

  always_comb begin
    nxt_tr    = tr_q;
    nxt_tc    = tc_q;
    nxt_line  = line_q + TILE_LG'(1);
    nxt_write = O_AG_CMD_WRITE;
    if (last_line) begin
      nxt_line  = '0;
      nxt_write = !O_AG_CMD_WRITE;
      if (O_AG_CMD_WRITE) begin
        if (last_col) begin
          nxt_tc = '0;
          nxt_tr = tr_q + DIM_W'(1);
        end else begin
          nxt_tc = tc_q + DIM_W'(1);
        end
      end
    end
  end

  // Destination tile of the next source tile
  logic [DIM_W-1:0] dr, dc;

  always_comb begin
    dr = nxt_tr;
    dc = nxt_tc;
    case (rot_q)
      2'd1: begin
        dr = nxt_tc;
        dc = th_q - DIM_W'(1) - nxt_tr;
      end
      2'd2: begin
        dr = th_q - DIM_W'(1) - nxt_tr;
        dc = tw_q - DIM_W'(1) - nxt_tc;
      end
      2'd3: begin
        dr = tw_q - DIM_W'(1) - nxt_tc;
        dc = nxt_tr;
      end
      default: ;
    endcase
  end

  // All products carried at full address width; wraps modulo 2^ADDR_W
  logic [ADDR_W-1:0] rd_row, wr_row, rd_addr, wr_addr, nxt_addr;

  assign rd_row   = (ADDR_W'(nxt_tr) << TILE_LG) + ADDR_W'(nxt_line);
  assign wr_row   = (ADDR_W'(dr) << TILE_LG) + ADDR_W'(nxt_line);
  assign rd_addr  = src_q + (rd_row * ADDR_W'(pw_q) + (ADDR_W'(nxt_tc) << TILE_LG)) * ADDR_W'(BPP);
  assign wr_addr  = dst_q + (wr_row * ADDR_W'(dw_q) + (ADDR_W'(dc) << TILE_LG)) * ADDR_W'(BPP);
  assign nxt_addr = nxt_write ? wr_addr : rd_addr;

  always_ff @(posedge I_AG_HCLK or negedge I_AG_HRESET_N) begin
    if (!I_AG_HRESET_N) begin
      state          <= IDLE;
      src_q          <= '0;
      dst_q          <= '0;
      pw_q           <= '0;
      dw_q           <= '0;
      th_q           <= '0;
      tw_q           <= '0;
      tr_q           <= '0;
      tc_q           <= '0;
      line_q         <= '0;
      rot_q          <= '0;
      O_AG_CMD_VALID <= 1'b0;
      O_AG_CMD_ADDR  <= '0;
      O_AG_CMD_WRITE <= 1'b0;
      O_AG_BUSY      <= 1'b0;
      O_AG_DONE      <= 1'b0;
      O_AG_ERR       <= 1'b0;
      O_AG_NEW_H     <= '0;
      O_AG_NEW_W     <= '0;
    end else begin
      O_AG_DONE <= 1'b0;
      O_AG_ERR  <= 1'b0;
      case (state)
        IDLE: begin
          if (I_AG_START) begin
            if (legal) begin
              state          <= READ;
              src_q          <= I_AG_SRC_BASE;
              dst_q          <= I_AG_DST_BASE;
              pw_q           <= pw_in;
              dw_q           <= rot_in[0] ? ph_in : pw_in;
              th_q           <= th_in;
              tw_q           <= tw_in;
              rot_q          <= rot_in;
              tr_q           <= '0;
              tc_q           <= '0;
              line_q         <= '0;
              O_AG_CMD_VALID <= 1'b1;
              O_AG_CMD_ADDR  <= I_AG_SRC_BASE;
              O_AG_CMD_WRITE <= 1'b0;
              O_AG_BUSY      <= 1'b1;
              O_AG_NEW_H     <= rot_in[0] ? pw_in : ph_in;
              O_AG_NEW_W     <= rot_in[0] ? ph_in : pw_in;
            end else begin
              O_AG_ERR <= 1'b1;
            end
          end
        end
        default: begin
          if (I_AG_ABORT) begin
            state          <= IDLE;
            tr_q           <= '0;
            tc_q           <= '0;
            line_q         <= '0;
            O_AG_CMD_VALID <= 1'b0;
            O_AG_CMD_WRITE <= 1'b0;
            O_AG_BUSY      <= 1'b0;
          end else if (O_AG_CMD_VALID && I_AG_CMD_READY) begin
            if (state == WRITE && last_line && last_row && last_col) begin
              state          <= IDLE;
              tr_q           <= '0;
              tc_q           <= '0;
              line_q         <= '0;
              O_AG_CMD_VALID <= 1'b0;
              O_AG_CMD_WRITE <= 1'b0;
              O_AG_BUSY      <= 1'b0;
              O_AG_DONE      <= 1'b1;
            end else begin
              state          <= nxt_write ? WRITE : READ;
              tr_q           <= nxt_tr;
              tc_q           <= nxt_tc;
              line_q         <= nxt_line;
              O_AG_CMD_WRITE <= nxt_write;
              O_AG_CMD_ADDR  <= nxt_addr;
            end
          end
        end
      endcase
    end
  end

endmodule
